// File: rtl/truth_table_checker.sv
// Response-side checker for exhaustive 3-input benches: samples z once per held
// vector after a settle window, builds the captured truth table and flags mismatches.
//
// state  | meaning
// IDLE   | waiting for start
// ARMED  | waiting for a valid vector
// SETTLE | vector latched, counting stable cycles
// SAMPLE | registering z for lat_abc and comparing against EXP_TT
// HOLD   | sample taken, waiting for the vector to change or drop
// DONE   | all 8 vectors seen, verdict held until start or reset
module truth_table_checker #(
    parameter logic [7:0] EXP_TT     = 8'hE8,
    parameter int         SETTLE_CYC = 4,
    parameter int         ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [2:0]       abc,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       captured_tt,
    output logic [7:0]       seen_mask,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [2:0]       first_err_abc
);

    typedef enum logic [2:0] {IDLE, ARMED, SETTLE, SAMPLE, HOLD, DONE} state_t;

    // The latch cycle is the first stable cycle, so the counter starts one short;
    // this puts the SAMPLE cycle exactly SETTLE_CYC cycles after the vector appears.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam state_t     AFTER_LATCH = (SETTLE_CYC == 1) ? SAMPLE : SETTLE;

    state_t     state;
    logic [2:0] lat_abc;
    logic [3:0] cnt;

    logic [7:0]       seen_next;
    logic             mismatch;
    logic [ERR_W-1:0] err_sat;
    logic [ERR_W-1:0] err_final;

    always_comb begin
        seen_next = seen_mask | (8'b1 << lat_abc);
        mismatch  = (z != EXP_TT[lat_abc]);
        err_sat   = (err_count == '1) ? err_count : err_count + ERR_W'(1);
        err_final = mismatch ? err_sat : err_count;
    end

    assign busy = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            lat_abc         <= '0;
            cnt             <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            captured_tt     <= '0;
            seen_mask       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_abc   <= '0;
        end else if (start) begin
            state           <= ARMED;
            cnt             <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            captured_tt     <= '0;
            seen_mask       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_abc   <= '0;
        end else begin
            case (state)
                IDLE: ;
                ARMED: begin
                    if (vec_valid) begin
                        lat_abc <= abc;
                        cnt     <= SETTLE_LOAD;
                        state   <= AFTER_LATCH;
                    end
                end
                SETTLE: begin
                    if (!vec_valid) begin
                        state <= ARMED;
                    end else if (abc != lat_abc) begin
                        lat_abc <= abc;
                        cnt     <= SETTLE_LOAD;
                        state   <= AFTER_LATCH;
                    end else if (cnt <= 4'd1) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    captured_tt[lat_abc] <= z;
                    seen_mask            <= seen_next;
                    err_count            <= err_final;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_abc   <= lat_abc;
                    end
                    if (seen_next == 8'hFF) begin
                        done  <= 1'b1;
                        pass  <= (err_final == '0);
                        state <= DONE;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!vec_valid) begin
                        state <= ARMED;
                    end else if (abc != lat_abc) begin
                        lat_abc <= abc;
                        cnt     <= SETTLE_LOAD;
                        state   <= AFTER_LATCH;
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: a queue of expected samples feeds a
// reference model of the captured table, error count and first-error record.
module tb_truth_table_checker;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, vec_valid, z;
    logic [2:0] abc;
    logic       busy, done, pass, first_err_valid;
    logic [7:0] captured_tt, seen_mask;
    logic [3:0] err_count;
    logic [2:0] first_err_abc;

    truth_table_checker #(.EXP_TT(8'hE8), .SETTLE_CYC(S), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .abc(abc), .z(z),
        .busy(busy), .done(done), .pass(pass), .captured_tt(captured_tt),
        .seen_mask(seen_mask), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_abc(first_err_abc)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [2:0] abc; logic z;} smp_t;
    smp_t sb_q[$];

    logic [7:0] exp_tt = 8'hE8;
    logic [7:0] m_cap, m_seen;
    int         m_err;
    logic       m_fv;
    logic [2:0] m_fabc;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_cap = '0; m_seen = '0; m_err = 0; m_fv = 1'b0; m_fabc = '0;
    endtask

    task automatic sb_drain();
        smp_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            m_cap[s.abc]  = s.z;
            m_seen[s.abc] = 1'b1;
            if (s.z != exp_tt[s.abc]) begin
                if (m_err < 15) m_err++;
                if (!m_fv) begin m_fv = 1'b1; m_fabc = s.abc; end
            end
        end
    endtask

    task automatic apply(input logic [2:0] a, input logic zz, input int hold, input bit sampled);
        vec_valid = 1'b1; abc = a; z = zz;
        if (sampled) sb_q.push_back('{abc: a, z: zz});
        repeat (hold) step();
    endtask

    task automatic go_idle(input int n);
        vec_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; abc = '0; z = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vec_valid = i[0]; abc = 3'(i); z = ~z; start = i[1];
            step();
        end
        n_tests++; if ({busy, done, pass, captured_tt, seen_mask, err_count, first_err_valid, first_err_abc} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0",
                {busy, done, pass, captured_tt, seen_mask, err_count, first_err_valid, first_err_abc});
        end
        start = 1'b0; rst_n = 1'b1;
        apply(3'b011, 1'b1, 6, 0);
        go_idle(1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_nostart_busy got=%b exp=0", busy); end
        n_tests++; if (seen_mask !== 8'h00) begin n_fail++; $display("FAIL reset_nostart_seen got=%h exp=00", seen_mask); end
    endtask

    task automatic test_golden();
        pulse_start();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL golden_busy got=%b exp=1", busy); end
        // first vector: sample must not be visible at cycle t+S, and must be at t+S+1
        vec_valid = 1'b1; abc = 3'b000; z = maj(3'b000);
        sb_q.push_back('{abc: 3'b000, z: maj(3'b000)});
        repeat (S) step();
        n_tests++; if (seen_mask !== 8'h00) begin n_fail++; $display("FAIL latency_early got=%h exp=00", seen_mask); end
        step();
        n_tests++; if (seen_mask !== 8'h01) begin n_fail++; $display("FAIL latency_ontime got=%h exp=01", seen_mask); end
        step();
        for (int i = 1; i < 8; i++) apply(3'(i), maj(3'(i)), 6, 1);
        sb_drain();
        n_tests++; if (captured_tt !== m_cap) begin n_fail++; $display("FAIL golden_tt got=%h exp=%h", captured_tt, m_cap); end
        n_tests++; if (captured_tt !== 8'hE8) begin n_fail++; $display("FAIL golden_tt_const got=%h exp=e8", captured_tt); end
        n_tests++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL golden_done_pass got=%b exp=11", {done, pass}); end
        n_tests++; if (err_count !== 4'(m_err)) begin n_fail++; $display("FAIL golden_err got=%0d exp=%0d", err_count, m_err); end
        n_tests++; if (first_err_valid !== m_fv) begin n_fail++; $display("FAIL golden_fv got=%b exp=%b", first_err_valid, m_fv); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL golden_busy_done got=%b exp=0", busy); end
    endtask

    task automatic test_fault();
        pulse_start();
        for (int i = 0; i < 8; i++) apply(3'(i), maj(3'(i)) ^ (i == 5), 6, 1);
        sb_drain();
        apply(3'b000, 1'b1, 6, 0);
        go_idle(1);
        n_tests++; if (captured_tt !== m_cap || m_cap !== 8'hC8) begin n_fail++; $display("FAIL fault_tt got=%h exp=c8", captured_tt); end
        n_tests++; if (err_count !== 4'(m_err)) begin n_fail++; $display("FAIL fault_err got=%0d exp=%0d", err_count, m_err); end
        n_tests++; if ({first_err_valid, first_err_abc} !== {m_fv, m_fabc}) begin
            n_fail++; $display("FAIL fault_first got=%b/%b exp=%b/%b", first_err_valid, first_err_abc, m_fv, m_fabc);
        end
        n_tests++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL fault_done_pass got=%b exp=10", {done, pass}); end
    endtask

    task automatic test_glitch();
        pulse_start();
        apply(3'b010, 1'b1, 2, 0);
        apply(3'b011, 1'b0, 6, 1);
        go_idle(2);
        sb_drain();
        n_tests++; if (seen_mask !== m_seen) begin n_fail++; $display("FAIL glitch_seen got=%h exp=%h", seen_mask, m_seen); end
        n_tests++; if (err_count !== 4'(m_err)) begin n_fail++; $display("FAIL glitch_err got=%0d exp=%0d", err_count, m_err); end
        n_tests++; if (first_err_abc !== m_fabc) begin n_fail++; $display("FAIL glitch_fabc got=%b exp=%b", first_err_abc, m_fabc); end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            apply(3'b000, 1'b1, 6, 1);
            go_idle(1);
        end
        sb_drain();
        n_tests++; if (err_count !== 4'(m_err) || m_err != 15) begin n_fail++; $display("FAIL sat_err got=%0d exp=15", err_count); end
        n_tests++; if ({first_err_valid, first_err_abc} !== {m_fv, m_fabc}) begin
            n_fail++; $display("FAIL sat_first got=%b/%b exp=%b/%b", first_err_valid, first_err_abc, m_fv, m_fabc);
        end
        n_tests++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL sat_done_busy got=%b exp=01", {done, busy}); end
        n_tests++; if (captured_tt !== m_cap) begin n_fail++; $display("FAIL sat_tt got=%h exp=%h", captured_tt, m_cap); end
    endtask

    task automatic test_reset_midrun();
        pulse_start();
        for (int i = 0; i < 4; i++) apply(3'(i), ~maj(3'(i)), 6, 1);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({busy, done, pass, captured_tt, seen_mask, err_count, first_err_valid, first_err_abc} !== 27'd0) begin
            n_fail++; $display("FAIL midrun_reset got=%h exp=0",
                {busy, done, pass, captured_tt, seen_mask, err_count, first_err_valid, first_err_abc});
        end
        step(); rst_n = 1'b1; step();
        vec_valid = 1'b1; abc = 3'b101; z = maj(3'b101);
        pulse_start();
        sb_q.push_back('{abc: 3'b101, z: maj(3'b101)});
        repeat (S) step();
        n_tests++; if (seen_mask !== 8'h00) begin n_fail++; $display("FAIL start_prio_early got=%h exp=00", seen_mask); end
        step();
        sb_drain();
        n_tests++; if (seen_mask !== m_seen) begin n_fail++; $display("FAIL start_prio_seen got=%h exp=%h", seen_mask, m_seen); end
        n_tests++; if ({captured_tt, err_count} !== {m_cap, 4'(m_err)}) begin
            n_fail++; $display("FAIL start_prio_tt_err got=%h/%0d exp=%h/%0d", captured_tt, err_count, m_cap, m_err);
        end
        go_idle(2);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_golden();
        test_fault();
        test_glitch();
        test_saturation();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
